// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath width, NOP encoding, fetch FSM states
// and the IF/ID pipeline register bundle.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_RUN   = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [31:0]     instr;
    } if_id_t;

    // Empty IF/ID slot: no instruction, NOP in the instruction field.
    localparam if_id_t IF_ID_BUBBLE = '{
        valid: 1'b0,
        pc:    32'h0000_0000,
        pc4:   32'h0000_0000,
        instr: NOP_INSTR
    };

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer for a fetch response that arrives
// while decode is stalled. Clear wins over load, load wins over drain.
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int SKID_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              drain,
    input  logic [SKID_W-1:0] load_pc,
    input  logic [31:0]       load_instr,
    output logic              full,
    output logic [SKID_W-1:0] pc,
    output logic [31:0]       instr
);

    logic              full_r;
    logic [SKID_W-1:0] pc_r;
    logic [31:0]       instr_r;

    // Entry storage and occupancy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r  <= 1'b0;
            pc_r    <= {SKID_W{1'b0}};
            instr_r <= NOP_INSTR;
        end else if (clear) begin
            full_r  <= 1'b0;
        end else if (load) begin
            full_r  <= 1'b1;
            pc_r    <= load_pc;
            instr_r <= load_instr;
        end else if (drain) begin
            full_r  <= 1'b0;
        end else begin
            full_r  <= full_r;
        end
    end

    assign full  = full_r;
    assign pc    = pc_r;
    assign instr = instr_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle-latency
// instruction memory and fills the IF/ID register, with a one-entry skid
// for responses that land while decode is stalled.
module if_stage #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int IMEM_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               id_stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_id_valid,
    output logic [XLEN-1:0]    if_id_pc,
    output logic [XLEN-1:0]    if_id_pc4,
    output logic [31:0]        if_id_instr
);
    import cpu_pkg::*;

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] req_pc_r;
    logic            inflight_r;
    logic [XLEN-1:0] fetch_pc_s;
    logic            fetch_s;
    logic            kill_s;
    fetch_state_t    state_r;
    fetch_state_t    state_nxt_s;
    if_id_t          if_id_r;
    if_id_t          if_id_nxt_s;
    logic            skid_clear_s;
    logic            skid_load_s;
    logic            skid_drain_s;
    logic            skid_full_s;
    logic [XLEN-1:0] skid_pc_s;
    logic [31:0]     skid_instr_s;
    logic            unused_rpc_lsb_s;

    // Word-aligned target; the low two redirect bits carry no information.
    assign fetch_pc_s       = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : pc_r;
    assign unused_rpc_lsb_s = ^redirect_pc[1:0];
    // A stall only blocks sequential fetch; a redirect always fetches its target.
    assign fetch_s          = !rst && (!id_stall || redirect_valid);
    assign kill_s           = flush || redirect_valid;
    assign imem_en          = fetch_s;
    assign imem_addr        = fetch_pc_s[IMEM_AW+1:2];

    // A stalled response parks in the skid unless it is being killed.
    assign skid_clear_s = kill_s;
    assign skid_load_s  = inflight_r && id_stall && !kill_s;
    assign skid_drain_s = skid_full_s && !id_stall && !kill_s;

    fetch_skid_buf #(
        .SKID_W (XLEN)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .clear      (skid_clear_s),
        .load       (skid_load_s),
        .drain      (skid_drain_s),
        .load_pc    (req_pc_r),
        .load_instr (imem_rdata),
        .full       (skid_full_s),
        .pc         (skid_pc_s),
        .instr      (skid_instr_s)
    );

    // PC advance and tracking of the request whose data returns next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            req_pc_r   <= {XLEN{1'b0}};
            inflight_r <= 1'b0;
        end else if (fetch_s) begin
            pc_r       <= fetch_pc_s + XLEN'(32'd4);
            req_pc_r   <= fetch_pc_s;
            inflight_r <= !(flush && !redirect_valid);
        end else begin
            inflight_r <= 1'b0;
        end
    end

    // IF/ID next value: flush, then stall, then redirect hold, then skid, then response.
    always_comb begin
        if_id_nxt_s = if_id_r;
        if (flush) begin
            if_id_nxt_s = IF_ID_BUBBLE;
        end else if (id_stall) begin
            if_id_nxt_s = if_id_r;
        end else if (redirect_valid) begin
            if_id_nxt_s = if_id_r;
        end else if (skid_full_s) begin
            if_id_nxt_s = '{valid: 1'b1, pc: skid_pc_s,
                            pc4: skid_pc_s + XLEN'(32'd4), instr: skid_instr_s};
        end else if (inflight_r) begin
            if_id_nxt_s = '{valid: 1'b1, pc: req_pc_r,
                            pc4: req_pc_r + XLEN'(32'd4), instr: imem_rdata};
        end else begin
            if_id_nxt_s = IF_ID_BUBBLE;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_r <= IF_ID_BUBBLE;
        end else begin
            if_id_r <= if_id_nxt_s;
        end
    end

    // Fetch FSM next state: HOLD tracks an occupied skid.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FS_RESET: begin
                if (fetch_s) begin
                    state_nxt_s = FS_RUN;
                end else begin
                    state_nxt_s = FS_RESET;
                end
            end
            FS_RUN: begin
                if (skid_load_s) begin
                    state_nxt_s = FS_HOLD;
                end else begin
                    state_nxt_s = FS_RUN;
                end
            end
            FS_HOLD: begin
                if (kill_s || !id_stall) begin
                    state_nxt_s = FS_RUN;
                end else begin
                    state_nxt_s = FS_HOLD;
                end
            end
            default: state_nxt_s = FS_RUN;
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FS_RESET;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign if_id_valid = if_id_r.valid;
    assign if_id_pc    = if_id_r.pc;
    assign if_id_pc4   = if_id_r.pc4;
    assign if_id_instr = if_id_r.instr;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory model with imem[i] = i+1, and a
// scoreboard of the PCs decode is expected to accept, in order.
module tb_if_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_q [$];
    int          checks;
    int          failures;
    bit          sb_on;

    if_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_instr    (if_id_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory, one cycle of read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decode accepts IF/ID on an edge where it holds a valid instr and no stall.
    always @(negedge clk) begin
        if (sb_on && !rst && if_id_valid && !id_stall) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra", {32'd0, if_id_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [31:0] e;
                logic [31:0] e4;
                logic [31:0] ei;
                e  = exp_q.pop_front();
                e4 = e + 32'd4;
                ei = {22'd0, e[11:2]} + 32'd1;
                check_eq("sb_pc", {32'd0, if_id_pc}, {32'd0, e});
                check_eq("sb_pc4", {32'd0, if_id_pc4}, {32'd0, e4});
                check_eq("sb_instr", {32'd0, if_id_instr}, {32'd0, ei});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] p);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (if_id_valid && if_id_pc == p) found = 1'b1;
        end
        if (!found) check_eq("wait_pc_timeout", {32'd0, if_id_pc}, {32'd0, p});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, {63'd0, if_id_valid}, 64'd0);
        check_eq({tag, "_pc"}, {32'd0, if_id_pc}, 64'd0);
        check_eq({tag, "_pc4"}, {32'd0, if_id_pc4}, 64'd0);
        check_eq({tag, "_instr"}, {32'd0, if_id_instr}, 64'h13);
        check_eq({tag, "_imem_en"}, {63'd0, imem_en}, 64'd0);
        check_eq({tag, "_state"}, 64'(dut.state_r), 64'(FS_RESET));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sb_on = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 1);
        rst = 1'b1;
        id_stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        repeat (2) tick();
        @(negedge clk);
        check_reset_outputs("rst");

        // Reset release, free-running fetch.
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
        @(negedge clk);
        check_eq("boot_en", {63'd0, imem_en}, 64'd1);
        check_eq("boot_addr0", {54'd0, imem_addr}, 64'd0);
        tick();
        @(negedge clk);
        check_eq("boot_valid_lat", {63'd0, if_id_valid}, 64'd0);
        check_eq("boot_addr1", {54'd0, imem_addr}, 64'd1);
        wait_pc(32'h4);

        // Three stalled edges with 0x8 in IF/ID: 0xC parks in the skid.
        tick();
        id_stall = 1'b1;
        @(negedge clk);
        check_eq("stall_en", {63'd0, imem_en}, 64'd0);
        check_eq("stall_pc", {32'd0, if_id_pc}, 64'h8);
        tick();
        @(negedge clk);
        check_eq("stall_hold_state", 64'(dut.state_r), 64'(FS_HOLD));
        check_eq("stall_hold_pc", {32'd0, if_id_pc}, 64'h8);
        tick();
        tick();
        id_stall = 1'b0;
        @(negedge clk);
        check_eq("release_en", {63'd0, imem_en}, 64'd1);
        check_eq("release_addr", {54'd0, imem_addr}, 64'd4);
        tick();
        @(negedge clk);
        check_eq("release_skid_pc", {32'd0, if_id_pc}, 64'hC);
        tick();
        @(negedge clk);
        check_eq("release_next_pc", {32'd0, if_id_pc}, 64'h10);
        check_eq("release_no_bubble", {63'd0, if_id_valid}, 64'd1);
        wait_pc(32'h14);

        // Redirect + flush to a misaligned target.
        tick();
        redirect_valid = 1'b1;
        flush = 1'b1;
        redirect_pc = 32'h43;
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        @(negedge clk);
        check_eq("redir_en", {63'd0, imem_en}, 64'd1);
        check_eq("redir_addr", {54'd0, imem_addr}, 64'h10);
        tick();
        redirect_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_valid", {63'd0, if_id_valid}, 64'd0);
        check_eq("flush_instr", {32'd0, if_id_instr}, 64'h13);
        tick();
        @(negedge clk);
        check_eq("redir_pc", {32'd0, if_id_pc}, 64'h40);
        check_eq("redir_pc4", {32'd0, if_id_pc4}, 64'h44);
        wait_pc(32'h44);

        // Redirect + flush + stall near the top of the address space.
        tick();
        redirect_valid = 1'b1;
        flush = 1'b1;
        id_stall = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        check_eq("wrap_redir_en", {63'd0, imem_en}, 64'd1);
        check_eq("wrap_redir_addr", {54'd0, imem_addr}, 64'h3FE);
        tick();
        redirect_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check_eq("wrap_flush_valid", {63'd0, if_id_valid}, 64'd0);
        check_eq("wrap_stall_en", {63'd0, imem_en}, 64'd0);
        tick();
        @(negedge clk);
        check_eq("wrap_skid_state", 64'(dut.state_r), 64'(FS_HOLD));
        tick();
        id_stall = 1'b0;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        @(negedge clk);
        check_eq("wrap_addr", {54'd0, imem_addr}, 64'h3FF);
        wait_pc(32'h0);
        wait_pc(32'h4);

        // Flush together with stall while the skid is full.
        tick();
        id_stall = 1'b1;
        tick();
        @(negedge clk);
        check_eq("fs_pre_state", 64'(dut.state_r), 64'(FS_HOLD));
        tick();
        flush = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        id_stall = 1'b0;
        exp_q.push_back(32'h80);
        @(negedge clk);
        check_eq("fs_valid", {63'd0, if_id_valid}, 64'd0);
        check_eq("fs_instr", {32'd0, if_id_instr}, 64'h13);
        check_eq("fs_state", 64'(dut.state_r), 64'(FS_RUN));
        check_eq("fs_skid_empty", {63'd0, dut.skid_full_s}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        flush = 1'b0;
        wait_pc(32'h80);

        // Reset while stalled with the skid full.
        tick();
        id_stall = 1'b1;
        tick();
        @(negedge clk);
        check_eq("mid_rst_pre_state", 64'(dut.state_r), 64'(FS_HOLD));
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        check_eq("sb_pending", 64'(exp_q.size()), 64'd0);
        id_stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        @(negedge clk);
        check_eq("restart_en", {63'd0, imem_en}, 64'd1);
        check_eq("restart_addr", {54'd0, imem_addr}, 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        sb_on = 1'b0;
        check_eq("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
